// File: rtl/vip_out_stream_if.sv
// Handshake bundle for the VIP output drain stage: FIFO read side plus
// the downstream valid/ready pixel stream with frame markers.
interface vip_out_stream_if #(
    parameter int DWIDTH = 24
);
    logic              enable;
    logic [DWIDTH-1:0] ff_rdata;
    logic              ff_empty;
    logic              ff_rdreq;
    logic [DWIDTH-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_sof;
    logic              out_eol;
    logic              out_eof;
    logic              frame_done;
    logic [15:0]       frame_cnt;

    // Drain stage side.
    modport master (
        input  enable, ff_rdata, ff_empty, out_ready,
        output ff_rdreq, out_data, out_valid, out_sof, out_eol, out_eof,
               frame_done, frame_cnt
    );

    // Environment side: FIFO and pixel sink.
    modport slave (
        output enable, ff_rdata, ff_empty, out_ready,
        input  ff_rdreq, out_data, out_valid, out_sof, out_eol, out_eof,
               frame_done, frame_cnt
    );
endinterface

// File: rtl/vip_out_stream.sv
// Output drain stage: reads a non-show-ahead FIFO into a 2-entry skid
// buffer and presents a valid/ready pixel stream tagged with SOF/EOL/EOF.
module vip_out_stream #(
    parameter int DWIDTH = 24,
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480
) (
    input  logic              clock,
    input  logic              reset,
    vip_out_stream_if.master  bus
);
    localparam int XW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

    logic [DWIDTH-1:0] mem [2];
    logic              rd_ptr;
    logic              wr_ptr;
    logic [1:0]        occ;
    logic              inflight;
    logic [XW-1:0]     x;
    logic [YW-1:0]     y;
    logic [15:0]       frame_cnt;
    logic              frame_done;

    logic              out_valid;
    logic              pop;
    logic              last_x;
    logic              last_y;
    logic [2:0]        level;

    assign out_valid = (occ != 2'd0);
    assign pop       = out_valid & bus.out_ready;
    assign last_x    = (x == XW'(WIDTH - 1));
    assign last_y    = (y == YW'(HEIGHT - 1));

    // Occupancy the buffer will have once this cycle's landing word and pop
    // are applied; a new read is only safe if that leaves room for its data.
    assign level = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};

    // Gated with reset so the FIFO is never popped while the stage is held.
    assign bus.ff_rdreq = ~reset & bus.enable & ~bus.ff_empty & (level < 3'd2);

    assign bus.out_valid  = out_valid;
    assign bus.out_data   = mem[rd_ptr];
    assign bus.out_sof    = out_valid & (x == '0) & (y == '0);
    assign bus.out_eol    = out_valid & last_x;
    assign bus.out_eof    = out_valid & last_x & last_y;
    assign bus.frame_done = frame_done;
    assign bus.frame_cnt  = frame_cnt;

    // Skid buffer: capture the word read last cycle, advance head on pop.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mem[0]   <= '0;
            mem[1]   <= '0;
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
            occ      <= 2'd0;
            inflight <= 1'b0;
        end else begin
            inflight <= bus.ff_rdreq;
            if (inflight) begin
                mem[wr_ptr] <= bus.ff_rdata;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            occ <= level[1:0];
        end
    end

    // Frame position tracking, advanced by each transferred beat.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            x          <= '0;
            y          <= '0;
            frame_cnt  <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= pop & last_x & last_y;
            if (pop) begin
                if (last_x) begin
                    x <= '0;
                    if (last_y) begin
                        y         <= '0;
                        frame_cnt <= frame_cnt + 16'd1;
                    end else begin
                        y <= y + YW'(1);
                    end
                end else begin
                    x <= x + XW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_vip_out_stream.sv
// Directed bench for vip_out_stream on a 4x2 frame, with a behavioural
// non-show-ahead FIFO and a cycle model of buffer fill and frame position.
module tb_vip_out_stream;
    localparam int DW = 24;
    localparam int W  = 4;
    localparam int H  = 2;

    logic clock = 1'b0;
    logic reset = 1'b1;

    // Free-running clock.
    always #5 clock = ~clock;

    vip_out_stream_if #(.DWIDTH(DW)) bus ();

    vip_out_stream #(.DWIDTH(DW), .WIDTH(W), .HEIGHT(H)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Source FIFO: no reset, data one cycle after the read request.
    logic [DW-1:0] fmem [0:255];
    int push_cnt = 0;
    int pop_cnt  = 0;
    assign bus.ff_empty = (push_cnt == pop_cnt);

    // FIFO read port.
    always @(posedge clock) begin
        if (bus.ff_rdreq) begin
            bus.ff_rdata <= fmem[pop_cnt[7:0]];
            pop_cnt      <= pop_cnt + 1;
        end
    end

    logic [DW-1:0] expq [$];
    int checks = 0, errors = 0;
    int lvl = 0, infl = 0, mx = 0, my = 0, frames = 0;
    logic done_pend = 1'b0;
    int cycle = 0, first_rd = -1, first_valid = -1, first_pop = -1, last_pop = -1;
    int rd_pulses = 0, pops = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [DW-1:0] w);
        fmem[push_cnt[7:0]] = w;
        push_cnt = push_cnt + 1;
        expq.push_back(w);
    endtask

    // One clock: drive ready/enable at the falling edge, check, update model.
    task automatic cyc(input logic rdy, input logic en);
        logic pop, exp_rd;
        logic [31:0] exp_data;
        @(negedge clock);
        bus.out_ready = rdy;
        bus.enable    = en;
        #1;
        cycle++;
        pop = bus.out_valid & rdy;
        chk("out_valid", 32'(bus.out_valid), 32'(lvl != 0));
        chk("frame_done", 32'(bus.frame_done), 32'(done_pend));
        chk("frame_cnt", 32'(bus.frame_cnt), 32'(frames[15:0]));
        exp_rd = en && (push_cnt != pop_cnt) && ((lvl + infl - (pop ? 1 : 0)) < 2);
        chk("ff_rdreq", 32'(bus.ff_rdreq), 32'(exp_rd));
        chk("buf_overrun", 32'(infl == 1 && lvl == 2 && !pop), 32'(0));
        if (bus.ff_rdreq && first_rd < 0) first_rd = cycle;
        if (bus.out_valid && first_valid < 0) first_valid = cycle;
        rd_pulses += bus.ff_rdreq ? 1 : 0;
        if (bus.out_valid) begin
            exp_data = (expq.size() != 0) ? 32'(expq[0]) : 32'hFFFF_FFFF;
            chk("out_data", 32'(bus.out_data), exp_data);
            chk("out_sof", 32'(bus.out_sof), 32'(mx == 0 && my == 0));
            chk("out_eol", 32'(bus.out_eol), 32'(mx == W-1));
            chk("out_eof", 32'(bus.out_eof), 32'(mx == W-1 && my == H-1));
        end
        done_pend = 1'b0;
        if (pop) begin
            if (expq.size() != 0) void'(expq.pop_front());
            if (first_pop < 0) first_pop = cycle;
            last_pop = cycle;
            pops++;
            if (mx == W-1) begin
                mx = 0;
                if (my == H-1) begin
                    my = 0;
                    frames++;
                    done_pend = 1'b1;
                end else my++;
            end else mx++;
        end
        lvl  = lvl + infl - (pop ? 1 : 0);
        infl = exp_rd ? 1 : 0;
        @(posedge clock);
        #1;
    endtask

    // Directed test sequence.
    initial begin
        bus.enable    = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_valid", 32'(bus.out_valid), 32'(0));
        chk("rst_rdreq", 32'(bus.ff_rdreq), 32'(0));
        chk("rst_data", 32'(bus.out_data), 32'(0));
        chk("rst_sof", 32'(bus.out_sof), 32'(0));
        chk("rst_eol", 32'(bus.out_eol), 32'(0));
        chk("rst_eof", 32'(bus.out_eof), 32'(0));
        chk("rst_done", 32'(bus.frame_done), 32'(0));
        chk("rst_fcnt", 32'(bus.frame_cnt), 32'(0));
        reset = 1'b0;

        // Full 4x2 frame at full rate.
        for (int i = 1; i <= 8; i++) push(DW'(i));
        repeat (14) cyc(1'b1, 1'b1);
        chk("latency", 32'(first_valid - first_rd), 32'(2));
        chk("back_to_back", 32'(last_pop - first_pop), 32'(7));
        chk("frame_cnt_1", 32'(bus.frame_cnt), 32'(1));
        chk("frame1_drain", 32'(expq.size()), 32'(0));

        // Back-pressure: buffer fills to 2, head holds.
        for (int i = 0; i < 6; i++) push(DW'(24'h11 + i));
        rd_pulses = 0;
        repeat (10) cyc(1'b0, 1'b1);
        chk("bp_rdreq", 32'(rd_pulses), 32'(2));
        chk("bp_hold", 32'(bus.out_data), 32'h11);
        repeat (10) cyc(1'b1, 1'b1);
        chk("bp_drain", 32'(expq.size()), 32'(0));

        // Enable dropped mid-line.
        for (int i = 0; i < 8; i++) push(DW'(24'h21 + i));
        repeat (3) cyc(1'b1, 1'b1);
        rd_pulses = 0;
        pops = 0;
        repeat (6) cyc(1'b1, 1'b0);
        chk("en_rdreq", 32'(rd_pulses), 32'(0));
        chk("en_pops", 32'(pops), 32'(2));
        chk("en_empty", 32'(bus.out_valid), 32'(0));
        repeat (12) cyc(1'b1, 1'b1);
        chk("en_drain", 32'(expq.size()), 32'(0));
        chk("frame_cnt_2", 32'(bus.frame_cnt), 32'(2));

        // Reset with a buffered word and one in flight.
        for (int i = 0; i < 4; i++) push(DW'(24'h31 + i));
        repeat (2) cyc(1'b0, 1'b1);
        reset = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(bus.out_valid), 32'(0));
        chk("mid_rst_rdreq", 32'(bus.ff_rdreq), 32'(0));
        chk("mid_rst_data", 32'(bus.out_data), 32'(0));
        chk("mid_rst_fcnt", 32'(bus.frame_cnt), 32'(0));
        for (int i = 0; i < lvl + infl; i++) void'(expq.pop_front());
        lvl = 0; infl = 0; mx = 0; my = 0; frames = 0; done_pend = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        repeat (3) cyc(1'b0, 1'b1);
        chk("post_rst_sof", 32'(bus.out_sof), 32'(1));
        chk("post_rst_data", 32'(bus.out_data), 32'h33);

        // Random back-pressure over three frames.
        begin
            int n;
            n = 24 - expq.size();
            for (int i = 0; i < n; i++) push(DW'(24'h100 + i));
        end
        for (int k = 0; k < 400 && expq.size() != 0; k++)
            cyc(1'($urandom_range(0, 1)), 1'b1);
        repeat (2) cyc(1'b1, 1'b1);
        chk("rand_drain", 32'(expq.size()), 32'(0));
        chk("rand_frames", 32'(bus.frame_cnt), 32'(3));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
